// File: rtl/hazard_ctrl.sv
// Pipeline interlock sequencer: turns load-use, branch and MDU hazards into per-stage
// stall/bubble/flush enables, stretching each hazard over its configured cycle count.
//   state    | meaning
//   RUN      | no hazard in progress; hazards act combinationally in the detection cycle
//   LU_STALL | holding PC and IF/ID, bubbling ID/EX for the remaining load-use cycles
//   FLUSH    | holding IF/ID clear for the remaining post-redirect cycles
//   MDU_WAIT | freezing the front end until the MDU completes or the watchdog fires
module hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int MDU_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             d_clk,
    input  logic             d_rst,
    input  logic             hc_i_load_use,
    input  logic             hc_i_branch_taken,
    input  logic             hc_i_mdu_start,
    input  logic             hc_i_mdu_done,
    output logic             hc_o_pc_stall,
    output logic             hc_o_fd_stall,
    output logic             hc_o_fd_flush,
    output logic             hc_o_ds_es_stall,
    output logic             hc_o_ds_es_bubble,
    output logic             hc_o_es_ms_bubble,
    output logic [1:0]       hc_o_state,
    output logic             hc_o_timeout,
    output logic [CNT_W-1:0] hc_o_stall_cnt
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_LU_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;
    localparam logic [1:0] S_MDU_WAIT = 2'd3;

    localparam int CNT_MAX = (LOAD_BUBBLES > FLUSH_CYCLES) ? LOAD_BUBBLES : FLUSH_CYCLES;
    localparam int HW      = $clog2(CNT_MAX + 1);
    localparam int WW      = $clog2(MDU_TIMEOUT + 1);

    localparam logic [HW-1:0] LU_RELOAD = HW'(LOAD_BUBBLES - 1);
    localparam logic [HW-1:0] FL_RELOAD = HW'(FLUSH_CYCLES - 1);
    localparam logic [HW-1:0] CNT_ONE   = HW'(1);
    localparam logic [WW-1:0] WD_LAST   = WW'(MDU_TIMEOUT - 1);
    localparam logic [WW-1:0] WD_ONE    = WW'(1);

    logic [1:0]       state_q, state_d;
    logic [HW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        wdog_d            = wdog_q;
        timeout_d         = timeout_q;
        hc_o_pc_stall     = 1'b0;
        hc_o_fd_stall     = 1'b0;
        hc_o_fd_flush     = 1'b0;
        hc_o_ds_es_stall  = 1'b0;
        hc_o_ds_es_bubble = 1'b0;
        hc_o_es_ms_bubble = 1'b0;
        case (state_q)
            S_RUN, S_LU_STALL: begin
                if (hc_i_branch_taken) begin
                    // Redirect wins: squash the wrong-path fetch and the ID consumer.
                    hc_o_fd_flush     = 1'b1;
                    hc_o_ds_es_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_d   = FL_RELOAD;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_RUN && hc_i_mdu_start) begin
                    hc_o_pc_stall     = 1'b1;
                    hc_o_fd_stall     = 1'b1;
                    hc_o_ds_es_stall  = 1'b1;
                    hc_o_es_ms_bubble = 1'b1;
                    wdog_d            = WD_ONE;
                    if (!hc_i_mdu_done) state_d = S_MDU_WAIT;
                end else if (state_q == S_LU_STALL || hc_i_load_use) begin
                    hc_o_pc_stall     = 1'b1;
                    hc_o_fd_stall     = 1'b1;
                    hc_o_ds_es_bubble = 1'b1;
                    if (state_q == S_LU_STALL) begin
                        if (cnt_q == CNT_ONE) state_d = S_RUN;
                        else                  cnt_d   = cnt_q - CNT_ONE;
                    end else if (LOAD_BUBBLES > 1) begin
                        cnt_d   = LU_RELOAD;
                        state_d = S_LU_STALL;
                    end
                end
            end
            S_FLUSH: begin
                hc_o_fd_flush = 1'b1;
                if (hc_i_branch_taken)   cnt_d   = FL_RELOAD;
                else if (cnt_q == CNT_ONE) state_d = S_RUN;
                else                     cnt_d   = cnt_q - CNT_ONE;
            end
            default: begin
                hc_o_pc_stall     = 1'b1;
                hc_o_fd_stall     = 1'b1;
                hc_o_ds_es_stall  = 1'b1;
                hc_o_es_ms_bubble = 1'b1;
                if (hc_i_mdu_done) begin
                    state_d = S_RUN;
                end else if (wdog_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hc_o_pc_stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hc_o_state     = state_q;
    assign hc_o_timeout   = timeout_q;
    assign hc_o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance A uses default parameters, instance B uses
// LOAD_BUBBLES=3, FLUSH_CYCLES=1 and a 4-bit stall counter for saturation.
module tb_hazard_ctrl;
    logic d_clk = 1'b0;
    logic d_rst = 1'b0;
    logic load_use = 1'b0, branch = 1'b0, mdu_start = 1'b0, mdu_done = 1'b0;

    logic        a_pc, a_fds, a_fdf, a_dss, a_dsb, a_esb, a_to;
    logic [1:0]  a_st;
    logic [15:0] a_cnt;
    logic        b_pc, b_fds, b_fdf, b_dss, b_dsb, b_esb, b_to;
    logic [1:0]  b_st;
    logic [3:0]  b_cnt;
    logic [5:0]  a_outs, b_outs;

    assign a_outs = {a_pc, a_fds, a_fdf, a_dss, a_dsb, a_esb};
    assign b_outs = {b_pc, b_fds, b_fdf, b_dss, b_dsb, b_esb};

    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_LU   = 6'b110010;
    localparam logic [5:0] O_BR   = 6'b001010;
    localparam logic [5:0] O_FL   = 6'b001000;
    localparam logic [5:0] O_MDU  = 6'b110101;

    int total = 0;
    int passed = 0;

    hazard_ctrl dut_a (
        .d_clk(d_clk), .d_rst(d_rst),
        .hc_i_load_use(load_use), .hc_i_branch_taken(branch),
        .hc_i_mdu_start(mdu_start), .hc_i_mdu_done(mdu_done),
        .hc_o_pc_stall(a_pc), .hc_o_fd_stall(a_fds), .hc_o_fd_flush(a_fdf),
        .hc_o_ds_es_stall(a_dss), .hc_o_ds_es_bubble(a_dsb), .hc_o_es_ms_bubble(a_esb),
        .hc_o_state(a_st), .hc_o_timeout(a_to), .hc_o_stall_cnt(a_cnt)
    );

    hazard_ctrl #(.LOAD_BUBBLES(3), .FLUSH_CYCLES(1), .MDU_TIMEOUT(64), .CNT_W(4)) dut_b (
        .d_clk(d_clk), .d_rst(d_rst),
        .hc_i_load_use(load_use), .hc_i_branch_taken(branch),
        .hc_i_mdu_start(mdu_start), .hc_i_mdu_done(mdu_done),
        .hc_o_pc_stall(b_pc), .hc_o_fd_stall(b_fds), .hc_o_fd_flush(b_fdf),
        .hc_o_ds_es_stall(b_dss), .hc_o_ds_es_bubble(b_dsb), .hc_o_es_ms_bubble(b_esb),
        .hc_o_state(b_st), .hc_o_timeout(b_to), .hc_o_stall_cnt(b_cnt)
    );

    always #5 d_clk = ~d_clk;

    task automatic cycle();
        @(posedge d_clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_use = 1'b0; branch = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        d_rst = 1'b0;
        cycle();
        cycle();
        d_rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        d_rst = 1'b0;
        #1;
        total++; if (a_outs !== O_IDLE) $display("FAIL rst_outs got %b exp %b", a_outs, O_IDLE); else passed++;
        total++; if (a_st !== 2'd0) $display("FAIL rst_state got %0d exp 0", a_st); else passed++;
        total++; if (a_cnt !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", a_cnt); else passed++;
        total++; if (a_to !== 1'b0) $display("FAIL rst_timeout got %b exp 0", a_to); else passed++;
        total++; if (b_st !== 2'd0) $display("FAIL rst_state_b got %0d exp 0", b_st); else passed++;
        do_reset();
    endtask

    task automatic test_load_use_single();
        do_reset();
        load_use = 1'b1;
        #1;
        total++; if (a_outs !== O_LU) $display("FAIL lu1_outs got %b exp %b", a_outs, O_LU); else passed++;
        cycle();
        load_use = 1'b0;
        #1;
        total++; if (a_outs !== O_IDLE) $display("FAIL lu1_after got %b exp %b", a_outs, O_IDLE); else passed++;
        total++; if (a_st !== 2'd0) $display("FAIL lu1_state got %0d exp 0", a_st); else passed++;
        total++; if (a_cnt !== 16'd1) $display("FAIL lu1_cnt got %0d exp 1", a_cnt); else passed++;
    endtask

    task automatic test_load_use_multi();
        logic [1:0] exp_st [4];
        logic [5:0] exp_o  [4];
        exp_st[0] = 2'd0; exp_st[1] = 2'd1; exp_st[2] = 2'd1; exp_st[3] = 2'd0;
        exp_o[0] = O_LU;  exp_o[1] = O_LU;  exp_o[2] = O_LU;  exp_o[3] = O_IDLE;
        do_reset();
        load_use = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (b_outs !== exp_o[i]) $display("FAIL lu3_outs[%0d] got %b exp %b", i, b_outs, exp_o[i]); else passed++;
            total++; if (b_st !== exp_st[i]) $display("FAIL lu3_state[%0d] got %0d exp %0d", i, b_st, exp_st[i]); else passed++;
            cycle();
            load_use = 1'b0;
        end
        total++; if (b_cnt !== 4'd3) $display("FAIL lu3_cnt got %0d exp 3", b_cnt); else passed++;
    endtask

    task automatic test_branch_priority();
        do_reset();
        branch = 1'b1; load_use = 1'b1;
        #1;
        total++; if (a_outs !== O_BR) $display("FAIL br_outs got %b exp %b", a_outs, O_BR); else passed++;
        total++; if (b_outs !== O_BR) $display("FAIL br_outs_b got %b exp %b", b_outs, O_BR); else passed++;
        cycle();
        clear_inputs();
        #1;
        total++; if (a_outs !== O_FL) $display("FAIL br_flush2 got %b exp %b", a_outs, O_FL); else passed++;
        total++; if (a_st !== 2'd2) $display("FAIL br_state got %0d exp 2", a_st); else passed++;
        total++; if (b_st !== 2'd0) $display("FAIL br_state_b got %0d exp 0", b_st); else passed++;
        total++; if (b_outs !== O_IDLE) $display("FAIL br_outs_b2 got %b exp %b", b_outs, O_IDLE); else passed++;
        cycle();
        total++; if (a_outs !== O_IDLE) $display("FAIL br_end got %b exp %b", a_outs, O_IDLE); else passed++;
        total++; if (a_st !== 2'd0) $display("FAIL br_state_end got %0d exp 0", a_st); else passed++;
        total++; if (a_cnt !== 16'd0) $display("FAIL br_cnt got %0d exp 0", a_cnt); else passed++;
    endtask

    task automatic test_lu_then_branch();
        do_reset();
        load_use = 1'b1;
        cycle();
        load_use = 1'b0; branch = 1'b1;
        #1;
        total++; if (b_outs !== O_BR) $display("FAIL lubr_outs got %b exp %b", b_outs, O_BR); else passed++;
        cycle();
        branch = 1'b0;
        #1;
        total++; if (b_st !== 2'd0) $display("FAIL lubr_state got %0d exp 0", b_st); else passed++;
        total++; if (b_cnt !== 4'd1) $display("FAIL lubr_cnt got %0d exp 1", b_cnt); else passed++;
    endtask

    task automatic test_mdu_done();
        do_reset();
        mdu_start = 1'b1;
        #1;
        total++; if (a_outs !== O_MDU) $display("FAIL mdu_issue got %b exp %b", a_outs, O_MDU); else passed++;
        cycle();
        mdu_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            mdu_done = (i == 5);
            branch   = (i == 2);
            load_use = (i == 3);
            #1;
            total++; if (a_outs !== O_MDU) $display("FAIL mdu_wait[%0d] got %b exp %b", i, a_outs, O_MDU); else passed++;
            total++; if (a_st !== 2'd3) $display("FAIL mdu_state[%0d] got %0d exp 3", i, a_st); else passed++;
            cycle();
        end
        clear_inputs();
        #1;
        total++; if (a_st !== 2'd0) $display("FAIL mdu_end_state got %0d exp 0", a_st); else passed++;
        total++; if (a_outs !== O_IDLE) $display("FAIL mdu_end_outs got %b exp %b", a_outs, O_IDLE); else passed++;
        total++; if (a_cnt !== 16'd6) $display("FAIL mdu_cnt got %0d exp 6", a_cnt); else passed++;
        mdu_start = 1'b1; mdu_done = 1'b1;
        #1;
        total++; if (a_outs !== O_MDU) $display("FAIL mdu1_outs got %b exp %b", a_outs, O_MDU); else passed++;
        cycle();
        clear_inputs();
        #1;
        total++; if (a_st !== 2'd0) $display("FAIL mdu1_state got %0d exp 0", a_st); else passed++;
        total++; if (a_cnt !== 16'd7) $display("FAIL mdu1_cnt got %0d exp 7", a_cnt); else passed++;
    endtask

    task automatic test_mdu_timeout();
        int n;
        logic to_early;
        do_reset();
        mdu_start = 1'b1;
        cycle();
        mdu_start = 1'b0;
        n = 1;
        to_early = 1'b0;
        while (a_st == 2'd3 && n < 200) begin
            if (a_to) to_early = 1'b1;
            cycle();
            n++;
        end
        total++; if (n !== 64) $display("FAIL to_cycles got %0d exp 64", n); else passed++;
        total++; if (to_early !== 1'b0) $display("FAIL to_early got %b exp 0", to_early); else passed++;
        total++; if (a_to !== 1'b1) $display("FAIL to_flag got %b exp 1", a_to); else passed++;
        total++; if (a_st !== 2'd0) $display("FAIL to_state got %0d exp 0", a_st); else passed++;
        total++; if (a_cnt !== 16'd64) $display("FAIL to_cnt got %0d exp 64", a_cnt); else passed++;
        mdu_start = 1'b1; mdu_done = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        total++; if (a_to !== 1'b1) $display("FAIL to_sticky got %b exp 1", a_to); else passed++;
    endtask

    task automatic test_reset_mid_mdu();
        do_reset();
        mdu_start = 1'b1;
        cycle();
        mdu_start = 1'b0;
        cycle();
        cycle();
        total++; if (a_st !== 2'd3) $display("FAIL rmid_pre got %0d exp 3", a_st); else passed++;
        d_rst = 1'b0;
        #1;
        total++; if (a_outs !== O_IDLE) $display("FAIL rmid_outs got %b exp %b", a_outs, O_IDLE); else passed++;
        total++; if (a_st !== 2'd0) $display("FAIL rmid_state got %0d exp 0", a_st); else passed++;
        total++; if (a_cnt !== 16'd0) $display("FAIL rmid_cnt got %0d exp 0", a_cnt); else passed++;
        cycle();
        d_rst = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        mdu_start = 1'b1;
        cycle();
        mdu_start = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            mdu_done = (i == 13);
            cycle();
        end
        clear_inputs();
        #1;
        total++; if (b_cnt !== 4'd14) $display("FAIL sat_pre got %0d exp 14", b_cnt); else passed++;
        load_use = 1'b1;
        cycle();
        load_use = 1'b0;
        total++; if (b_cnt !== 4'd15) $display("FAIL sat_1 got %0d exp 15", b_cnt); else passed++;
        cycle();
        cycle();
        total++; if (b_cnt !== 4'd15) $display("FAIL sat_hold got %0d exp 15", b_cnt); else passed++;
        total++; if (b_st !== 2'd0) $display("FAIL sat_state got %0d exp 0", b_st); else passed++;
    endtask

    initial begin
        cycle();
        test_reset();
        test_load_use_single();
        test_load_use_multi();
        test_branch_priority();
        test_lu_then_branch();
        test_mdu_done();
        test_mdu_timeout();
        test_reset_mid_mdu();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
